// File: rtl/mem_arbiter.sv
// Shares one single-ported SRAM between a fetch port and a data port, one access in flight.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin ties; otherwise data beats fetch.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_bytesel,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              s_read,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_dataD,
  output logic [3:0]        s_byteSel,
  input  logic [31:0]       s_dataQ,
  input  logic              s_ready
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

  state_e      state_q;
  logic        gnt_d_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        d_req;
  logic        pick_d;
  logic        done;

  assign d_req = d_read | d_write;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // Set when the data port won the most recent grant; reset means fetch was last.
  logic last_d_q;
  assign pick_d = d_req & (~i_req | ~last_d_q);
`else
  assign pick_d = d_req;
`endif

  assign done    = (state_q == StWait) & s_ready;
  assign i_ready = done & ~gnt_d_q;
  assign d_ready = done & gnt_d_q;
  assign i_rdata = i_ready ? s_dataQ : i_rdata_q;
  assign d_rdata = d_ready ? s_dataQ : d_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_d_q   <= 1'b0;
      s_read    <= 1'b0;
      s_write   <= 1'b0;
      s_addr    <= '0;
      s_dataD   <= '0;
      s_byteSel <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (d_req || i_req) begin
            gnt_d_q   <= pick_d;
            s_addr    <= pick_d ? d_addr : i_addr;
            // A simultaneous read and write is treated as a write.
            s_read    <= pick_d ? ~d_write : 1'b1;
            s_write   <= pick_d & d_write;
            s_byteSel <= (pick_d && d_write) ? d_bytesel : 4'b1111;
            if (pick_d) begin
              s_dataD <= d_wdata;
            end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_d_q  <= pick_d;
`endif
            state_q   <= StAccess;
          end
        end
        StAccess: begin
          s_read  <= 1'b0;
          s_write <= 1'b0;
          state_q <= StWait;
        end
        StWait: begin
          if (s_ready) begin
            if (gnt_d_q) begin
              d_rdata_q <= s_dataQ;
            end else begin
              i_rdata_q <= s_dataQ;
            end
            state_q <= StIdle;
          end
        end
        default: begin
          s_read  <= 1'b0;
          s_write <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: SRAM responder, transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [11:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_read;
  logic        d_write;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_bytesel;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        s_read;
  logic        s_write;
  logic [11:0] s_addr;
  logic [31:0] s_dataD;
  logic [3:0]  s_byteSel;
  logic [31:0] s_dataQ;
  logic        s_ready;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int stall_cfg = 0;

  logic [31:0] sram_mem [4096];
  logic [31:0] ref_mem  [4096];

  mem_arbiter #(.ADDR_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_bytesel (d_bytesel),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .s_read    (s_read),
    .s_write   (s_write),
    .s_addr    (s_addr),
    .s_dataD   (s_dataD),
    .s_byteSel (s_byteSel),
    .s_dataQ   (s_dataQ),
    .s_ready   (s_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM: samples a request on an edge, answers stall_cfg+1 cycles later. Ignores reset.
  bit          sr_pend = 0;
  int          sr_wait = 0;
  initial begin
    s_ready = 1'b0;
    s_dataQ = '0;
    forever begin
      @(posedge clk);
      if (sr_pend) begin
        if (sr_wait == 0) sr_pend = 0;
        else sr_wait--;
      end
      if (s_read || s_write) begin
        sr_pend = 1;
        sr_wait = stall_cfg;
        s_dataQ = sram_mem[s_addr];
        if (s_write) begin
          for (int b = 0; b < 4; b++)
            if (s_byteSel[b]) sram_mem[s_addr][8*b +: 8] = s_dataD[8*b +: 8];
        end
      end
      #1;
      s_ready = sr_pend && (sr_wait == 0);
    end
  end

  // Transaction model: one access at a time, ready at age 1+stall after the grant edge.
  bit          m_busy    = 0;
  bit          m_port_d  = 0;
  bit          m_wr      = 0;
  bit          m_last_d  = 0;
  bit          m_d_valid = 1;
  bit          m_want_d;
  int          m_age     = 0;
  int          m_stall   = 0;
  logic [11:0] m_addr    = '0;
  logic [31:0] m_wdata   = '0;
  logic [3:0]  m_be      = '0;
  logic [31:0] m_exp     = '0;
  logic [31:0] m_i_rdata = '0;
  logic [31:0] m_d_rdata = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_age = 0; m_last_d = 0;
      m_i_rdata = '0; m_d_rdata = '0; m_d_valid = 1;
    end else if (m_busy) begin
      if (m_age == 1 + m_stall) begin
        m_busy = 0;
        if (!m_port_d) m_i_rdata = m_exp;
        else if (!m_wr) begin m_d_rdata = m_exp; m_d_valid = 1; end
        else m_d_valid = 0;
      end else begin
        m_age++;
      end
    end else if (i_req || d_read || d_write) begin
      m_want_d = d_read || d_write;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      m_port_d = m_want_d && !(i_req && m_last_d);
`else
      m_port_d = m_want_d;
`endif
      m_last_d = m_port_d;
      m_wr     = m_port_d && d_write;
      m_addr   = m_port_d ? d_addr : i_addr;
      m_be     = m_wr ? d_bytesel : 4'b1111;
      m_wdata  = d_wdata;
      m_exp    = ref_mem[m_addr];
      if (m_wr) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) ref_mem[m_addr][8*b +: 8] = m_wdata[8*b +: 8];
      end
      m_stall = stall_cfg;
      m_age   = 0;
      m_busy  = 1;
    end
  end

  bit e_done;
  bit e_acc;
  initial forever begin
    @(negedge clk);
    e_done = m_busy && (m_age == 1 + m_stall);
    e_acc  = m_busy && (m_age == 0);
    chk("i_ready", 32'(i_ready), 32'(e_done && !m_port_d));
    chk("d_ready", 32'(d_ready), 32'(e_done && m_port_d));
    chk("s_read",  32'(s_read),  32'(e_acc && !m_wr));
    chk("s_write", 32'(s_write), 32'(e_acc && m_wr));
    if (e_acc) begin
      chk("s_addr",    32'(s_addr),    32'(m_addr));
      chk("s_byteSel", 32'(s_byteSel), 32'(m_be));
      if (m_wr) chk("s_dataD", s_dataD, m_wdata);
    end
    chk("i_rdata", i_rdata, (e_done && !m_port_d) ? m_exp : m_i_rdata);
    if (e_done && m_port_d && !m_wr) chk("d_rdata", d_rdata, m_exp);
    else if (!(e_done && m_port_d) && m_d_valid) chk("d_rdata_hold", d_rdata, m_d_rdata);
  end

  task automatic clear_inputs();
    i_req = 0; i_addr = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0; d_bytesel = '0;
  endtask

  task automatic wait_ready(input int budget, output int rc, output bit was_d,
                            output logic [31:0] rdv);
    bit got;
    got = 0; rc = -1; was_d = 0; rdv = '0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        got = 1; rc = cyc; was_d = d_ready;
        rdv = d_ready ? d_rdata : i_rdata;
      end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout: got no ready, required one within %0d cycles", budget);
    end
  endtask

  task automatic access(input bit use_d, input bit rd, input bit wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int lat, output logic [31:0] rdv);
    int t0; int rc; bit wasd;
    @(posedge clk); #2;
    if (use_d) begin
      d_read = rd; d_write = wr; d_addr = a; d_wdata = wd; d_bytesel = be;
    end else begin
      i_req = 1; i_addr = a;
    end
    t0 = cyc;
    wait_ready(40, rc, wasd, rdv);
    lat = rc - t0;
    @(posedge clk); #2;
    clear_inputs();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 0;
    @(posedge clk); #2;
    rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat; int t0; int rc; bit wasd; logic [31:0] rdv; logic [3:0] seq;
    int rcs [3];
    for (int k = 0; k < 4096; k++) begin
      sram_mem[k] = '0; ref_mem[k] = '0;
    end
    sram_mem[12'h010] = 32'hDEADBEEF; ref_mem[12'h010] = 32'hDEADBEEF;
    rst_n = 0;
    clear_inputs();

    @(negedge clk);
    chk("rst_s_read",    32'(s_read),    32'd0);
    chk("rst_s_addr",    32'(s_addr),    32'd0);
    chk("rst_s_byteSel", 32'(s_byteSel), 32'd0);
    chk("rst_i_rdata",   i_rdata,        32'd0);
    @(posedge clk); #2;
    rst_n = 1;

    access(0, 0, 0, 12'h010, '0, '0, lat, rdv);
    chk("fetch_lat",   32'(lat), 32'd2);
    chk("fetch_rdata", rdv,      32'hDEADBEEF);

    access(1, 0, 1, 12'h020, 32'h11223344, 4'b0101, lat, rdv);
    chk("bytewr_lat", 32'(lat), 32'd2);
    access(1, 1, 0, 12'h020, '0, '0, lat, rdv);
    chk("bytewr_readback", rdv, 32'h00220044);

    // Read and write together must behave as a write.
    access(1, 1, 1, 12'h030, 32'hA5A5A5A5, 4'b1111, lat, rdv);
    access(0, 0, 0, 12'h030, '0, '0, lat, rdv);
    chk("rdwr_is_write", rdv, 32'hA5A5A5A5);

    @(posedge clk); #2;
    d_read = 1; d_addr = 12'h010;
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      wait_ready(20, rc, wasd, rdv);
      rcs[k] = rc - t0;
      chk("b2b_port_d", 32'(wasd), 32'd1);
    end
    @(posedge clk); #2;
    clear_inputs();
    chk("b2b_ready0", 32'(rcs[0]), 32'd2);
    chk("b2b_ready1", 32'(rcs[1]), 32'd5);
    chk("b2b_ready2", 32'(rcs[2]), 32'd8);

    stall_cfg = 5;
    access(1, 1, 0, 12'h020, '0, '0, lat, rdv);
    chk("stall_lat",   32'(lat), 32'd7);
    chk("stall_rdata", rdv,      32'h00220044);
    stall_cfg = 3;

    // Fetch in flight, reset lands while waiting; the late SRAM answer must be ignored.
    @(posedge clk); #2;
    i_req = 1; i_addr = 12'h010;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    chk("midrst_s_read",  32'(s_read),  32'd0);
    chk("midrst_s_addr",  32'(s_addr),  32'd0);
    chk("midrst_s_dataD", s_dataD,      32'd0);
    chk("midrst_d_rdata", d_rdata,      32'd0);
    chk("midrst_i_ready", 32'(i_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    repeat (6) @(posedge clk);
    stall_cfg = 0;
    access(0, 0, 0, 12'h010, '0, '0, lat, rdv);
    chk("postrst_lat",   32'(lat), 32'd2);
    chk("postrst_rdata", rdv,      32'hDEADBEEF);

    pulse_reset();
    @(posedge clk); #2;
    i_req = 1; i_addr = 12'h010;
    d_read = 1; d_addr = 12'h020;
    seq = '0;
    for (int k = 0; k < 4; k++) begin
      wait_ready(20, rc, wasd, rdv);
      seq = {seq[2:0], wasd};
      chk("tie_rdata", rdv, wasd ? 32'h00220044 : 32'hDEADBEEF);
    end
    @(posedge clk); #2;
    clear_inputs();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    chk("tie_grants", 32'(seq), 32'(4'b1010));
`else
    chk("tie_grants", 32'(seq), 32'(4'b1111));
`endif

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
